// File: rtl/ntt_input_packer.sv
// -----------------------------------------------------------------------------
// ntt_input_packer
//
// Upstream loader for the 32-lane NTT core. Collects one polynomial of N
// coefficients from a valid/ready stream, then bursts it to the NTT as BEATS
// contiguous beats of INPUT_PER_CYCLE lanes. A start pulse marks beat 0.
// Filling and draining never overlap, so the buffer is a single frame deep.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset (deassert synchronously)
//   in_valid   in   coefficient present
//   in_ready   out  packer accepts a coefficient (FILL only)
//   in_data    in   coefficient, natural order (index 0 first)
//   in_last    in   marks coefficient N-1; checked only, framing is by count
//   dst_ready  in   NTT can take a new frame; sampled only while waiting
//   out_valid  out  beat valid
//   out_start  out  high with beat 0 only
//   out_data   out  beat; lane i at [i*W +: W]; zero when out_valid is low
//   frame_err  out  sticky in_last mismatch flag, cleared only by reset
// -----------------------------------------------------------------------------
module ntt_input_packer #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 32,
    parameter int N                    = 2048
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_WIDTH_PER_INPUT-1:0]              in_data,
    input  logic                                         in_last,
    input  logic                                         dst_ready,
    output logic                                         out_valid,
    output logic                                         out_start,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] out_data,
    output logic                                         frame_err
);

    localparam int BEATS  = N / INPUT_PER_CYCLE;
    localparam int LANE_W = $clog2(INPUT_PER_CYCLE);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int COEF_W = $clog2(N);
    localparam int ROW_W  = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // One row per output beat so the drain reads a whole beat per cycle.
    logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] r_mem [BEATS];

    state_t              r_state;
    logic [COEF_W-1:0]   r_coef_cnt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_start;
    logic [ROW_W-1:0]    r_out_data;
    logic                r_frame_err;

    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [BEAT_W-1:0]   w_rd_idx;
    logic                w_in_ready_nxt;
    logic                w_out_valid_nxt;
    logic                w_out_start_nxt;
    logic [ROW_W-1:0]    w_out_data_nxt;
    logic                w_hs;
    logic                w_last_coef;
    logic [BEAT_W-1:0]   w_wr_beat;
    logic [LANE_W-1:0]   w_wr_lane;

    // in_ready is only ever high in FILL, so a handshake implies FILL.
    assign w_hs        = in_valid & r_in_ready;
    assign w_last_coef = (r_coef_cnt == COEF_W'(N - 1));
    assign w_wr_beat   = r_coef_cnt[COEF_W-1:LANE_W];
    assign w_wr_lane   = r_coef_cnt[LANE_W-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat_cnt;
        w_rd_idx        = '0;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = 1'b0;
        w_out_start_nxt = 1'b0;
        unique case (r_state)
            S_FILL: begin
                w_in_ready_nxt = 1'b1;
                if (w_hs && w_last_coef) begin
                    w_state_nxt    = S_WAIT;
                    w_in_ready_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                w_in_ready_nxt = 1'b0;
                if (dst_ready) begin
                    // Beat 0 is registered out on the same edge that enters DRAIN.
                    w_state_nxt     = S_DRAIN;
                    w_beat_nxt      = '0;
                    w_rd_idx        = '0;
                    w_out_valid_nxt = 1'b1;
                    w_out_start_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                // r_beat_cnt is the beat currently on the output.
                if (r_beat_cnt == BEAT_W'(BEATS - 1)) begin
                    w_state_nxt    = S_FILL;
                    w_beat_nxt     = '0;
                    w_in_ready_nxt = 1'b1;
                end else begin
                    w_beat_nxt      = r_beat_cnt + BEAT_W'(1);
                    w_rd_idx        = r_beat_cnt + BEAT_W'(1);
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_FILL;
                w_in_ready_nxt = 1'b0;
            end
        endcase
        w_out_data_nxt = w_out_valid_nxt ? r_mem[w_rd_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FILL;
            r_coef_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_data  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_start <= w_out_start_nxt;
            r_out_data  <= w_out_data_nxt;
            if (w_hs) begin
                // Counter wraps to 0 naturally after coefficient N-1.
                r_coef_cnt <= r_coef_cnt + COEF_W'(1);
                if (in_last != w_last_coef) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    // Buffer holds data only; it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_mem[w_wr_beat][w_wr_lane] <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_start = r_out_start;
    assign out_data  = r_out_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ntt_input_packer.sv
module tb_ntt_input_packer;

    localparam int W     = 28;
    localparam int L     = 32;
    localparam int N     = 2048;
    localparam int BEATS = N / L;
    localparam int ROW_W = W * L;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             dst_ready;
    logic             out_valid;
    logic             out_start;
    logic [ROW_W-1:0] out_data;
    logic             frame_err;

    ntt_input_packer #(
        .DATA_WIDTH_PER_INPUT(W),
        .INPUT_PER_CYCLE(L),
        .N(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .dst_ready(dst_ready),
        .out_valid(out_valid),
        .out_start(out_start),
        .out_data(out_data),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted coefficients in order; each output beat
    // consumes the next L of them, lane i taking the i-th.
    logic [W-1:0]     exp_q[$];
    logic [ROW_W-1:0] cap_data[$];
    logic             cap_start[$];
    int               cap_cyc[$];
    logic             post_rdy_q[$];
    int               cyc = 0;
    int               idle_bad = 0;
    logic             prev_valid = 1'b0;
    logic             err_before_last = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            cap_data.push_back(out_data);
            cap_start.push_back(out_start);
            cap_cyc.push_back(cyc);
        end else if (out_data !== '0 || out_start !== 1'b0) begin
            idle_bad++;
        end
        if (prev_valid && out_valid !== 1'b1) post_rdy_q.push_back(in_ready);
        prev_valid = (out_valid === 1'b1);
    end

    // mode: 0 ramp (value = index), 1 all ones, 2 random.
    task automatic send_frame(input int mode, input int gap_pct, input int last_at, input int count);
        int k = 0;
        int guard = 0;
        logic rdy;
        logic [W-1:0] v;
        while (k < count && guard < 40000) begin
            guard++;
            v = (mode == 0) ? W'(k) : (mode == 1) ? {W{1'b1}} : W'($urandom);
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = in_valid ? v : W'($urandom);
            in_last  = in_valid ? (k == last_at) : 1'($urandom_range(0, 1));
            rdy = in_ready;
            if (in_valid && rdy && k == N - 1) err_before_last = frame_err;
            @(posedge clk); #1;
            if (in_valid && rdy) begin
                exp_q.push_back(v);
                k++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (k !== count) begin
            errors++;
            $display("FAIL send_count got %0d required %0d", k, count);
        end
        if (count == N) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_fall got %b required 0", in_ready);
            end
        end
    endtask

    task automatic check_frame(input string name);
        int g = 0;
        int c0;
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] exp_row;
        logic st;
        int cy;
        int lane;
        while (cap_data.size() < BEATS && g < 3000) begin
            @(posedge clk); #2;
            g++;
        end
        checks++;
        if (cap_data.size() < BEATS || exp_q.size() < N) begin
            errors++;
            $display("FAIL %s_beats got %0d required %0d (model %0d)", name, cap_data.size(), BEATS, exp_q.size());
            return;
        end
        c0 = cap_cyc[0];
        for (int b = 0; b < BEATS; b++) begin
            row = cap_data.pop_front();
            st  = cap_start.pop_front();
            cy  = cap_cyc.pop_front();
            for (int i = 0; i < L; i++) exp_row[i*W +: W] = exp_q.pop_front();
            checks++;
            if (row !== exp_row) begin
                errors++;
                lane = 0;
                for (int i = L - 1; i >= 0; i--) if (row[i*W +: W] !== exp_row[i*W +: W]) lane = i;
                $display("FAIL %s_data beat %0d lane %0d got %h required %h", name, b, lane, row[lane*W +: W], exp_row[lane*W +: W]);
            end
            checks++;
            if (st !== (b == 0)) begin
                errors++;
                $display("FAIL %s_start beat %0d got %b required %b", name, b, st, (b == 0));
            end
            checks++;
            if (cy !== c0 + b) begin
                errors++;
                $display("FAIL %s_contig beat %0d got cycle %0d required %0d", name, b, cy, c0 + b);
            end
        end
        g = 0;
        while (post_rdy_q.size() == 0 && g < 10) begin
            @(posedge clk); #2;
            g++;
        end
        checks++;
        if (post_rdy_q.size() == 0) begin
            errors++;
            $display("FAIL %s_ready_after got none required 1", name);
        end else begin
            st = post_rdy_q.pop_front();
            if (st !== 1'b1) begin
                errors++;
                $display("FAIL %s_ready_after got %b required 1", name, st);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL %s_idle_zero got %0d nonzero idle cycles required 0", name, idle_bad);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b required 0 0", in_ready, out_valid);
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready, out_valid, out_start, frame_err} !== 4'b0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs got rdy=%b vld=%b st=%b err=%b data_nz=%b required all 0",
                         in_ready, out_valid, out_start, frame_err, (out_data !== '0));
            end
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_ramp();
        dst_ready = 1'b1;
        send_frame(0, 0, N - 1, N);
        check_frame("ramp");
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ramp_frame_err got %b required 0", frame_err);
        end
    endtask

    task automatic test_backpressure();
        int g = 0;
        dst_ready = 1'b0;
        send_frame(0, 30, N - 1, N);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cap_data.size() !== 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_wait got beats=%0d rdy=%b required 0 0", cap_data.size(), in_ready);
        end
        dst_ready = 1'b1;
        while (cap_data.size() < 21 && g < 200) begin
            @(posedge clk); #2;
            g++;
        end
        dst_ready = 1'b0;
        check_frame("bp");
        dst_ready = 1'b1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_frame_err got %b required 0", frame_err);
        end
    endtask

    task automatic test_frame_err();
        send_frame(2, 20, 100, N);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL err_early_last got %b required 1", frame_err);
        end
        check_frame("err_a");
        apply_reset();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got %b required 0", frame_err);
        end
        send_frame(2, 10, -1, N);
        checks++;
        if (err_before_last !== 1'b0 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL err_missing_last got before=%b after=%b required 0 1", err_before_last, frame_err);
        end
        check_frame("err_b");
    endtask

    task automatic test_mid_reset();
        send_frame(0, 10, -1, 1000);
        apply_reset();
        repeat (100) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cap_data.size() !== 0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort got beats=%0d err=%b required 0 0", cap_data.size(), frame_err);
        end
        send_frame(0, 0, N - 1, N);
        check_frame("midreset");
    endtask

    task automatic test_back_to_back();
        // in_valid stays high through WAIT/DRAIN between frames; none of it may be taken.
        send_frame(1, 0, N - 1, N);
        send_frame(1, 0, N - 1, N);
        send_frame(0, 0, N - 1, N);
        check_frame("b2b_max1");
        check_frame("b2b_max2");
        check_frame("b2b_ramp");
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame_err got %b required 0", frame_err);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_last   = 1'b0;
        dst_ready = 1'b1;
        test_reset();
        test_ramp();
        test_backpressure();
        test_frame_err();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_input_packer.md
Name: ntt_input_packer

Overview:
- Upstream loader for the N=2048, 32-lane NTT core.
- Accepts one 28-bit coefficient per cycle on a valid/ready stream and buffers a full polynomial.
- Once the polynomial is complete, bursts it to the NTT as 64 contiguous beats of 32 lanes, with a start pulse on the first beat.
- Replaces the rotating-counter scatter used for IO-limited builds with a framed, back-pressured input path.

Parameters:
- DATA_WIDTH_PER_INPUT, 28, bits per coefficient/lane.
- INPUT_PER_CYCLE, 32, lanes per output beat; power of two.
- N, 2048, coefficients per polynomial; multiple of INPUT_PER_CYCLE.
- Derived (not overridable): BEATS = N/INPUT_PER_CYCLE (64), LANE_W = log2(INPUT_PER_CYCLE), BEAT_W = log2(BEATS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  coefficient present.
- in_ready  out  1  packer can accept a coefficient.
- in_data  in  DATA_WIDTH_PER_INPUT  coefficient, natural order (index 0 first).
- in_last  in  1  marks coefficient N-1; checked only, never used for framing.
- dst_ready  in  1  NTT can start a new frame; sampled only in WAIT.
- out_valid  out  1  beat valid.
- out_start  out  1  high with beat 0 only.
- out_data  out  INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT  beat; lane i at [i*W +: W].
- frame_err  out  1  sticky in_last mismatch flag.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert):
  - FSM=FILL, coef_cnt=0, beat_cnt=0.
  - in_ready=0, out_valid=0, out_start=0, out_data=0, frame_err=0.
  - Buffer contents are not reset.
- First clock edge with rst=1: in_ready=1 (FILL).
- Mapping: coefficient k is stored at beat k>>LANE_W, lane k&(INPUT_PER_CYCLE-1).
- FSM FILL:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data and increments coef_cnt.
  - Handshake at coef_cnt=N-1 → WAIT next cycle; in_ready=0 from that cycle.
  - coef_cnt wraps to 0.
- FSM WAIT:
  - in_ready=0.
  - dst_ready=1 in any WAIT cycle → DRAIN on the next edge, with beat 0 registered out.
- FSM DRAIN:
  - out_valid=1 for exactly BEATS consecutive cycles; out_start=1 on beat 0 only.
  - out_data = buffer row beat_cnt, registered.
  - dst_ready is ignored; no stall is possible.
  - After beat BEATS-1 → FILL; in_ready=1 on the cycle after the last beat.
- Outputs when invalid: out_data=0 and out_start=0 whenever out_valid=0.
- Throughput: a frame costs at least N + 1 + BEATS cycles (2113). Filling and draining do not overlap.
- in_last check (framing is by count only):
  - in_last=1 on a handshake with coef_cnt≠N-1 → frame_err←1.
  - in_last=0 on the handshake with coef_cnt=N-1 → frame_err←1.
  - frame_err is cleared only by reset.
- Idle inputs: in_valid=1 while in_ready=0 is not accepted; in_data is not sampled.
- Reset mid-fill or mid-drain: the partial frame is discarded and no further out_valid occurs. The next frame starts at coef_cnt=0.
- Arithmetic: data passes through unmodified; no modular reduction and no width change.

Test Plan:
- Reset check:
  - Stimulus: hold rst=0 for 5 cycles with in_valid=1, dst_ready=1.
  - Required: all outputs 0 throughout; in_ready=1 on the first edge after release.
- Ramp frame:
  - Stimulus: in_data=k for k=0..2047, contiguous, in_last on k=2047, dst_ready=1.
  - Required: in_ready falls after the 2048th handshake.
  - Beat 0 has out_start=1 and lane i=i; beat 63 lane 31=2047.
  - 64 contiguous out_valid cycles; frame_err=0.
- Backpressure:
  - Stimulus: random in_valid gaps; dst_ready=0 for 10 WAIT cycles, then 1; dst_ready dropped at beat 20.
  - Required: no out_valid before dst_ready rises; data identical to the ramp frame; drain not interrupted.
- Framing errors:
  - Stimulus (a): in_last at k=100.
  - Required (a): frame_err=1; output still 64 beats.
  - Stimulus (b): after reset, a frame with no in_last.
  - Required (b): frame_err=1 after handshake 2047.
- Mid-frame reset:
  - Stimulus: assert rst at k=1000, release, send a full ramp frame.
  - Required: no out_valid from the aborted frame; the new frame is output correctly.
- Max values, back-to-back:
  - Stimulus: two back-to-back frames of all 2^28-1 (0xFFFFFFF), then ramp.
  - Required: every lane 0xFFFFFFF in frames 1–2, ramp correct in frame 3; in_ready=1 the cycle after each final beat.
